risc16_program_sequencer: RTL and testbench

Upstream feed stage for the RISC_16 core. It replaces switch-driven manual instruction entry with a small on-chip program store. Programs are loaded byte by byte from board switches in LOAD mode. In RUN mode the stored program is streamed into the core's instruction input, synchronised to the core's one-hot stage tick, so that a stable instruction is present at every fetch stage.

---
 rtl/risc16_pkg.sv | 19 +
 rtl/risc16_prog_ram.sv | 27 ++
 rtl/risc16_program_sequencer.sv | 160 ++++++++++++++++
 tb/tb_risc16_program_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared definitions for the RISC_16 program sequencer: stage tick codes,
// instruction width, default NOP and the sequencer state type.
package risc16_pkg;

    localparam int INSTR_W = 16;

    localparam logic [4:0] TICK_FETCH = 5'b10000;
    localparam logic [4:0] TICK_LAST  = 5'b00001;

    localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/risc16_prog_ram.sv
// Program store: DEPTH x 16 words, one synchronous write port and one
// asynchronous read port whose result is registered by the sequencer.
module risc16_prog_ram
    import risc16_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/risc16_program_sequencer.sv
// Feeds the RISC_16 core from a small on-chip program store: bytes are loaded
// from switches in LOAD mode, then streamed one word per core instruction in RUN.
module risc16_program_sequencer
    import risc16_pkg::*;
#(
    parameter int                 DEPTH    = 16,
    parameter bit                 WRAP     = 1'b0,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run_mode,
    input  logic                       wr_stb,
    input  logic                       byte_sel,
    input  logic [7:0]                 wr_data,
    input  logic [4:0]                 tick,
    output logic [INSTR_W-1:0]         instruction,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic [$clog2(DEPTH):0]     prog_len,
    output logic                       halted,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    seq_state_e         state_q, state_d;
    logic               wr_stb_q;
    logic [7:0]         hold_lo_q, hold_lo_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [LW-1:0]      len_q, len_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;

    logic               stb_edge;
    logic [LW-1:0]      next_idx;
    logic               mem_we;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;

    assign stb_edge = wr_stb & ~wr_stb_q;
    assign next_idx = {1'b0, pc_q} + LW'(1);

    // PRIME and a wrap both fetch entry 0; an in-range advance fetches next_idx.
    assign rd_addr = (state_q == RUN && next_idx < len_q) ? next_idx[AW-1:0] : '0;

    risc16_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (len_q[AW-1:0]),
        .wr_data ({wr_data, hold_lo_q}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        hold_lo_d = hold_lo_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        len_d     = len_q;
        halted_d  = halted_q;
        err_d     = err_q;
        mem_we    = 1'b0;

        if (state_q != LOAD && stb_edge) begin
            err_d = 1'b1;
        end

        case (state_q)
            LOAD: begin
                instr_d = NOP_WORD;
                if (stb_edge) begin
                    if (!byte_sel) begin
                        hold_lo_d = wr_data;
                    end else if (len_q < FULL) begin
                        mem_we = 1'b1;
                        len_d  = len_q + LW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (run_mode) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (len_q == '0) begin
                    instr_d  = NOP_WORD;
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    instr_d = rd_data;
                    pc_d    = '0;
                    state_d = RUN;
                end
            end
            RUN, HALT: begin
                // Dropping run_mode takes priority over a coincident advance tick.
                if (!run_mode) begin
                    instr_d  = NOP_WORD;
                    halted_d = 1'b0;
                    pc_d     = '0;
                    state_d  = LOAD;
                end else if (state_q == HALT) begin
                    instr_d = NOP_WORD;
                end else if (tick == TICK_LAST) begin
                    if (next_idx < len_q) begin
                        instr_d = rd_data;
                        pc_d    = next_idx[AW-1:0];
                    end else if (WRAP) begin
                        instr_d = rd_data;
                        pc_d    = '0;
                    end else begin
                        instr_d  = NOP_WORD;
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD;
            wr_stb_q  <= 1'b0;
            hold_lo_q <= 8'h00;
            instr_q   <= NOP_WORD;
            pc_q      <= '0;
            len_q     <= '0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_stb_q  <= wr_stb;
            hold_lo_q <= hold_lo_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            halted_q  <= halted_d;
            err_q     <= err_d;
        end
    end

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign prog_len    = len_q;
    assign halted      = halted_q;
    assign err         = err_q;

endmodule

// File: tb/tb_risc16_program_sequencer.sv
// Bench for risc16_program_sequencer: a halting and a wrapping instance share
// stimulus; a vector table, hand sequences and random traffic check both.
module tb_risc16_program_sequencer;
    import risc16_pkg::*;

    localparam int DEPTH = 16;
    localparam logic [15:0] NOP = 16'h0000;

    localparam int M_LOAD  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;
    localparam int M_HALT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_mode, wr_stb, byte_sel;
    logic [7:0]  wr_data;
    logic [4:0]  tick;

    logic [15:0] instr0, instr1;
    logic [3:0]  pc0, pc1;
    logic [4:0]  len0, len1;
    logic        halted0, halted1, err0, err1;

    always #5 clk = ~clk;

    risc16_program_sequencer #(.DEPTH(DEPTH), .WRAP(1'b0), .NOP_WORD(NOP)) dut0 (
        .clk(clk), .rst(rst), .run_mode(run_mode), .wr_stb(wr_stb), .byte_sel(byte_sel),
        .wr_data(wr_data), .tick(tick), .instruction(instr0), .pc(pc0), .prog_len(len0),
        .halted(halted0), .err(err0)
    );

    risc16_program_sequencer #(.DEPTH(DEPTH), .WRAP(1'b1), .NOP_WORD(NOP)) dut1 (
        .clk(clk), .rst(rst), .run_mode(run_mode), .wr_stb(wr_stb), .byte_sel(byte_sel),
        .wr_data(wr_data), .tick(tick), .instruction(instr1), .pc(pc1), .prog_len(len1),
        .halted(halted1), .err(err1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one per instance (index 0 halts, index 1 wraps).
    logic [15:0] m_mem [2][DEPTH];
    int          m_len  [2];
    int          m_pc   [2];
    int          m_mode [2];
    logic [7:0]  m_hold [2];
    logic        m_err  [2];
    logic        m_halt [2];
    logic        m_prev [2];

    logic [4:0]  tick_seq [5] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};

    typedef struct {
        logic        run;
        logic        stb;
        logic        bsel;
        logic [7:0]  data;
        logic [4:0]  tck;
        logic [15:0] e_instr;
        logic [3:0]  e_pc;
        logic [4:0]  e_len;
        logic        e_halted;
        logic        e_err;
        logic [15:0] e1_instr;
        logic [3:0]  e1_pc;
        logic        e1_halted;
    } vec_t;

    vec_t vecs[$];

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] expInstr(input int w);
        return (m_mode[w] == M_RUN) ? m_mem[w][m_pc[w]] : NOP;
    endfunction

    task automatic modelReset();
        for (int w = 0; w < 2; w++) begin
            m_len[w]  = 0;
            m_pc[w]   = 0;
            m_mode[w] = M_LOAD;
            m_hold[w] = 8'h00;
            m_err[w]  = 1'b0;
            m_halt[w] = 1'b0;
            m_prev[w] = 1'b0;
        end
    endtask

    task automatic modelStep(input logic r, input logic s, input logic b,
                             input logic [7:0] d, input logic [4:0] t);
        for (int w = 0; w < 2; w++) begin
            logic edge_seen;
            edge_seen = s && !m_prev[w];
            m_prev[w] = s;
            if (m_mode[w] == M_LOAD) begin
                if (edge_seen) begin
                    if (!b) begin
                        m_hold[w] = d;
                    end else if (m_len[w] < DEPTH) begin
                        m_mem[w][m_len[w]] = {d, m_hold[w]};
                        m_len[w]++;
                    end else begin
                        m_err[w] = 1'b1;
                    end
                end
                if (r) m_mode[w] = M_PRIME;
            end else begin
                if (edge_seen) m_err[w] = 1'b1;
                if (m_mode[w] == M_PRIME) begin
                    if (m_len[w] == 0) begin
                        m_halt[w] = 1'b1;
                        m_mode[w] = M_HALT;
                    end else begin
                        m_pc[w]   = 0;
                        m_mode[w] = M_RUN;
                    end
                end else if (!r) begin
                    m_mode[w] = M_LOAD;
                    m_halt[w] = 1'b0;
                    m_pc[w]   = 0;
                end else if (m_mode[w] == M_RUN && t == TICK_LAST) begin
                    if (m_pc[w] + 1 < m_len[w]) begin
                        m_pc[w]++;
                    end else if (w == 1) begin
                        m_pc[w] = 0;
                    end else begin
                        m_halt[w] = 1'b1;
                        m_mode[w] = M_HALT;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("dut0.instruction", instr0, expInstr(0));
        checkVal("dut0.pc", 16'(pc0), 16'(m_pc[0]));
        checkVal("dut0.prog_len", 16'(len0), 16'(m_len[0]));
        checkVal("dut0.halted", 16'(halted0), 16'(m_halt[0]));
        checkVal("dut0.err", 16'(err0), 16'(m_err[0]));
        checkVal("dut1.instruction", instr1, expInstr(1));
        checkVal("dut1.pc", 16'(pc1), 16'(m_pc[1]));
        checkVal("dut1.prog_len", 16'(len1), 16'(m_len[1]));
        checkVal("dut1.halted", 16'(halted1), 16'(m_halt[1]));
        checkVal("dut1.err", 16'(err1), 16'(m_err[1]));
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic [7:0] d, input logic [4:0] t);
        run_mode = r;
        wr_stb   = s;
        byte_sel = b;
        wr_data  = d;
        tick     = t;
        @(posedge clk);
        modelStep(r, s, b, d, t);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic loadWord(input logic [15:0] w);
        applyStimulus(1'b0, 1'b1, 1'b0, w[7:0], 5'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, w[7:0], 5'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, w[15:8], 5'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, w[15:8], 5'b0);
    endtask

    task automatic advance();
        for (int j = 0; j < 5; j++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, tick_seq[j]);
    endtask

    task automatic addVec(input logic r, input logic s, input logic b, input logic [7:0] d,
                          input logic [4:0] t, input logic [15:0] ei, input logic [3:0] ep,
                          input logic [4:0] el, input logic eh, input logic ee,
                          input logic [15:0] ei1, input logic [3:0] ep1, input logic eh1);
        vec_t v;
        v = '{r, s, b, d, t, ei, ep, el, eh, ee, ei1, ep1, eh1};
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] words [4];
        int rot;
        words = '{16'h1234, 16'h5678, 16'h9ABC, 16'h0000};

        // Load 1234 / 5678 / 9ABC, run through all three words, then poke the halted store.
        addVec(0, 1, 0, 8'h34, 0, NOP, 0, 0, 0, 0, NOP, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, NOP, 0, 0, 0, 0, NOP, 0, 0);
        addVec(0, 1, 1, 8'h12, 0, NOP, 0, 1, 0, 0, NOP, 0, 0);
        addVec(0, 0, 1, 8'h00, 0, NOP, 0, 1, 0, 0, NOP, 0, 0);
        addVec(0, 1, 0, 8'h78, 0, NOP, 0, 1, 0, 0, NOP, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, NOP, 0, 1, 0, 0, NOP, 0, 0);
        addVec(0, 1, 1, 8'h56, 0, NOP, 0, 2, 0, 0, NOP, 0, 0);
        addVec(0, 0, 1, 8'h00, 0, NOP, 0, 2, 0, 0, NOP, 0, 0);
        addVec(0, 1, 0, 8'hBC, 0, NOP, 0, 2, 0, 0, NOP, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, NOP, 0, 2, 0, 0, NOP, 0, 0);
        addVec(0, 1, 1, 8'h9A, 0, NOP, 0, 3, 0, 0, NOP, 0, 0);
        addVec(0, 0, 1, 8'h00, 0, NOP, 0, 3, 0, 0, NOP, 0, 0);
        addVec(1, 0, 0, 8'h00, 0, NOP, 0, 3, 0, 0, NOP, 0, 0);
        addVec(1, 0, 0, 8'h00, 0, 16'h1234, 0, 3, 0, 0, 16'h1234, 0, 0);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++)
                addVec(1, 0, 0, 8'h00, tick_seq[j], words[k], 4'(k), 3, 0, 0, words[k], 4'(k), 0);
            if (k < 2)
                addVec(1, 0, 0, 8'h00, tick_seq[4], words[k+1], 4'(k+1), 3, 0, 0,
                       words[k+1], 4'(k+1), 0);
            else
                addVec(1, 0, 0, 8'h00, tick_seq[4], NOP, 2, 3, 1, 0, 16'h1234, 0, 0);
        end
        addVec(1, 1, 0, 8'h00, 0, NOP, 2, 3, 1, 1, 16'h1234, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, NOP, 0, 3, 0, 1, NOP, 0, 0);

        run_mode = 1'b0; wr_stb = 1'b0; byte_sel = 1'b0; wr_data = 8'h00; tick = 5'b0;
        doReset();
        checkVal("reset.instruction", instr0, NOP);
        checkVal("reset.prog_len", 16'(len0), 16'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].run, vecs[i].stb, vecs[i].bsel, vecs[i].data, vecs[i].tck);
            checkVal($sformatf("vec%0d.instr", i), instr0, vecs[i].e_instr);
            checkVal($sformatf("vec%0d.pc", i), 16'(pc0), 16'(vecs[i].e_pc));
            checkVal($sformatf("vec%0d.len", i), 16'(len0), 16'(vecs[i].e_len));
            checkVal($sformatf("vec%0d.halted", i), 16'(halted0), 16'(vecs[i].e_halted));
            checkVal($sformatf("vec%0d.err", i), 16'(err0), 16'(vecs[i].e_err));
            checkVal($sformatf("vec%0d.wrap_instr", i), instr1, vecs[i].e1_instr);
            checkVal($sformatf("vec%0d.wrap_pc", i), 16'(pc1), 16'(vecs[i].e1_pc));
            checkVal($sformatf("vec%0d.wrap_halted", i), 16'(halted1), 16'(vecs[i].e1_halted));
        end

        // Append to fill the store, then overflow it with a 17th word.
        for (int i = 3; i < 16; i++) loadWord(16'hA000 + 16'(i));
        checkVal("fill.prog_len", 16'(len0), 16'd16);
        loadWord(16'hDEAD);
        checkVal("overflow.prog_len", 16'(len0), 16'd16);
        checkVal("overflow.err", 16'(err0), 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 5'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 5'b0);
        checkVal("full.first", instr0, 16'h1234);
        for (int i = 0; i < 15; i++) advance();
        checkVal("full.mem15", instr0, 16'hA00F);
        checkVal("full.pc15", 16'(pc0), 16'd15);
        advance();
        checkVal("full.halt", 16'(halted0), 16'd1);
        checkVal("full.wrap_instr", instr1, 16'h1234);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 5'b0);

        // A strobe held high commits once; a strobe in RUN only raises err.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h11, 5'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h11, 5'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'h22, 5'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h22, 5'b0);
        checkVal("hold.prog_len", 16'(len0), 16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 5'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 5'b0);
        checkVal("hold.word", instr0, 16'h2211);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, TICK_FETCH);
        checkVal("runstb.err", 16'(err0), 16'd1);
        checkVal("runstb.instr", instr0, 16'h2211);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 5'b01000);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 5'b00100);
        doReset();
        checkVal("midrst.instr", instr0, NOP);
        checkVal("midrst.pc", 16'(pc0), 16'd0);
        checkVal("midrst.prog_len", 16'(len0), 16'd0);
        checkVal("midrst.err", 16'(err0), 16'd0);

        // Random traffic against the model, with occasional resets.
        rot = 0;
        for (int c = 0; c < 4000; c++) begin
            logic       r_run;
            logic [4:0] r_tick;
            r_run = ($urandom_range(0, 59) == 0) ? ~run_mode : run_mode;
            if ($urandom_range(0, 99) < 85) begin
                r_tick = 5'b10000 >> rot;
                rot = (rot + 1) % 5;
            end else begin
                r_tick = 5'($urandom_range(0, 31));
            end
            applyStimulus(r_run, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)), r_tick);
            if ($urandom_range(0, 499) == 0) doReset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
